// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by pc_reg and fetch_ctrl.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: load, increment modulo 2^W, or hold.
// Emits a registered one-cycle pulse when it wraps from all-ones to 0.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int          W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] pc_o,
  output logic         wrap_o
);

  logic [W-1:0] pc_d, pc_q;
  logic         wrap_d, wrap_q;

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d   = pc_q + 1'b1;
      wrap_d = &pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc_o   = pc_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: FSM plus registered valid/ready output stage.
// Drives the external ROM address straight from the PC.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = HALT_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  jmp,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  output logic [ADDR_WIDTH-1:0] rom_a,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted,
  output logic                  pc_wrap
);

  fetch_state_t state_d, state_q;

  logic [DATA_WIDTH-1:0] instr_d, instr_q;
  logic [ADDR_WIDTH-1:0] ipc_d, ipc_q;
  logic                  valid_d, valid_q;

  logic                  pc_load, pc_inc;
  logic [ADDR_WIDTH-1:0] pc_load_val, pc;
  logic                  slot, is_halt;

  assign slot    = !valid_q || instr_ready;
  assign is_halt = (rom_q == HALT_WORD);

  pc_reg #(
    .W       (ADDR_WIDTH),
    .RST_VAL (START_ADDR)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc),
    .wrap_o     (pc_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!jmp && slot && is_halt) state_d = HALTED;
      HALTED:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = START_ADDR;
    pc_inc      = 1'b0;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    valid_d     = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) pc_load = 1'b1;
      end
      RUN: begin
        // A jump flushes the stage and suppresses the fetch this cycle.
        if (jmp) begin
          pc_load     = 1'b1;
          pc_load_val = jmp_addr;
          valid_d     = 1'b0;
        end else if (slot) begin
          instr_d = rom_q;
          ipc_d   = pc;
          valid_d = 1'b1;
          pc_inc  = !is_halt;
        end
      end
      HALTED: begin
        if (start) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (valid_q && instr_ready) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign rom_a       = pc;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALTED);

endmodule
